spi_rx_master: RTL
==================

Name: spi_rx_master

Overview:
- Parametrised successor to the single-word serial reader: SPI-style master receiver generating cs_n/sclk_n and shifting in from_device.
- Adds configurable word width, sclk divider, words per frame, bit order, explicit start/busy handshake, per-word valid strobe, end-of-frame strobe and ena-based pause.
- Sits between an external read-only serial device (ADC/sensor) and the local fabric.

Parameters:
- WIDTH, 8, bits per word (>=2)
- DIV, 2, clk cycles per sclk half-period (>=1)
- WORDS, 1, words per cs_n frame (>=1)
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = in data_out[0]

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_a  in  1  reset, synchronous, active-high
- ena  in  1  clock enable; 0 freezes all state, counters and outputs
- start  in  1  frame request, sampled only in IDLE with ena=1
- from_device  in  1  serial data from device
- sclk_n  out  1  serial clock, idle high
- cs_n  out  1  chip select, active low
- busy  out  1  high from accepted start until return to IDLE
- data_out  out  WIDTH  last completed word, held until next word completes
- data_valid  out  1  one-cycle strobe, data_out updated
- frame_done  out  1  one-cycle strobe at end of frame

Behaviour:
- Reset (rst_a=1 at posedge, overrides ena): state IDLE, cs_n=1, sclk_n=1, busy=0, data_out=0, data_valid=0, frame_done=0, all counters 0. Mid-frame reset aborts immediately; no data_valid/frame_done issued.
- All outputs registered. Cycle counts below are ena=1 cycles; ena=0 cycles are inserted transparently (strobes stretch only if ena drops during them: strobes are cleared on the next ena=1 edge).
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE: cs_n=1, sclk_n=1, busy=0. start=1 at edge t0 -> SETUP; at t0: cs_n<=0, busy<=1.
- SETUP: DIV cycles, sclk_n=1, then -> LOW.
- LOW: DIV cycles, sclk_n=0. On the final LOW edge from_device is sampled into the shift register and sclk_n<=1; -> HIGH.
- HIGH: DIV cycles, sclk_n=1. Bit counter 0..WIDTH-1, word counter 0..WORDS-1. After HIGH: if more bits/words remain -> LOW (no gap between words); else -> HOLD.
- Word completion: on the edge sampling bit WIDTH-1, data_out<=assembled word (including that bit), data_valid<=1 for one cycle. Bit counter wraps to 0, word counter increments.
- HOLD: DIV cycles, cs_n=0, sclk_n=1; on exit cs_n<=1, frame_done<=1 (one cycle) -> GAP.
- GAP: DIV cycles, cs_n=1, busy=1, start ignored; then busy<=0 -> IDLE. start held high re-triggers on first IDLE cycle (back-to-back frames spaced by GAP+1).
- start while busy: ignored, not queued.
- cs_n low duration = DIV*(2 + 2*WIDTH*WORDS) cycles; sclk_n falling edges per frame = WIDTH*WORDS exactly.
- Bit order: MSB_FIRST=1 shifts left (new bit at LSB); 0 shifts right (new bit at MSB).
- Counters sized by $clog2 with minimum 1 bit; no overflow at WIDTH or WORDS powers of two.

Test Plan:
- Defaults, device sends 0xA5 MSB-first on sclk_n falling edges, start pulse -> cs_n low 36 cycles, 8 sclk_n low pulses of 2 cycles, data_valid once with data_out=0xA5, frame_done on first cs_n-high cycle, busy low 2 cycles later.
- WIDTH=12, WORDS=3, DIV=1, words 0xABC,0x123,0xFFF -> three data_valid strobes 24 cycles apart with those values, no sclk gap between words, cs_n low 74 cycles, one frame_done.
- MSB_FIRST=0, serial bit stream 1,0,0,0,0,0,0,0 -> data_out=0x01.
- ena toggled 1/0 every other cycle mid-frame -> identical sclk_n/cs_n sequence and data_out as the ena=1 run, stretched 2x; no extra sclk edges.
- rst_a asserted during bit 4 -> next cycle cs_n=1, sclk_n=1, busy=0, data_out=0, no data_valid/frame_done; later start gives normal frame.
- start held high continuously, defaults -> repeating frames, cs_n high exactly DIV+1=3 cycles between frames; start pulses during busy have no effect.

Source files
------------

// File: rtl/spi_rx_master.sv
`default_nettype none
// ============================================================================
// spi_rx_master : SPI-style master receiver (cs_n/sclk_n generation, word shift-in)
// Revision 1.0
// ============================================================================
module spi_rx_master #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 2,
  parameter int WORDS     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             ena,
  input  logic             start,
  input  logic             from_device,
  output logic             sclk_n,
  output logic             cs_n,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_done
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [WW-1:0]    word_cnt, word_cnt_d;
  logic [WIDTH-2:0] partial, partial_d;
  logic [WIDTH-1:0] assembled;
  logic [WIDTH-1:0] data_out_d;
  logic             last_word, last_word_d;
  logic             sclk_n_d, cs_n_d, busy_d, data_valid_d, frame_done_d;
  logic             phase_end;

  // Only WIDTH-1 earlier bits need storing; the word is completed with the live sample.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign assembled = {partial, from_device};
      assign partial_d = (state == LOW && phase_end && ena) ? assembled[WIDTH-2:0] : partial;
    end else begin : g_lsb_first
      assign assembled = {from_device, partial};
      assign partial_d = (state == LOW && phase_end && ena) ? assembled[WIDTH-1:1] : partial;
    end
  endgenerate

  assign phase_end = (cnt == CNT_LAST);

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_cnt_d    = bit_cnt;
    word_cnt_d   = word_cnt;
    last_word_d  = last_word;
    data_out_d   = data_out;
    sclk_n_d     = sclk_n;
    cs_n_d       = cs_n;
    busy_d       = busy;
    data_valid_d = data_valid;
    frame_done_d = frame_done;
    if (ena) begin
      data_valid_d = 1'b0;
      frame_done_d = 1'b0;
      cnt_d        = phase_end ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d     = SETUP;
            cs_n_d      = 1'b0;
            busy_d      = 1'b1;
            bit_cnt_d   = '0;
            word_cnt_d  = '0;
            last_word_d = 1'b0;
          end
        end
        SETUP: if (phase_end) begin
          state_d  = LOW;
          sclk_n_d = 1'b0;
        end
        LOW: if (phase_end) begin
          state_d  = HIGH;
          sclk_n_d = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            data_out_d   = assembled;
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            last_word_d  = (word_cnt == WORD_LAST);
            word_cnt_d   = (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
        HIGH: if (phase_end) begin
          if (last_word) begin
            state_d = HOLD;
          end else begin
            state_d  = LOW;
            sclk_n_d = 1'b0;
          end
        end
        HOLD: if (phase_end) begin
          state_d      = GAP;
          cs_n_d       = 1'b1;
          frame_done_d = 1'b1;
        end
        GAP: if (phase_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      last_word  <= 1'b0;
      partial    <= '0;
      data_out   <= '0;
      sclk_n     <= 1'b1;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      word_cnt   <= word_cnt_d;
      last_word  <= last_word_d;
      partial    <= partial_d;
      data_out   <= data_out_d;
      sclk_n     <= sclk_n_d;
      cs_n       <= cs_n_d;
      busy       <= busy_d;
      data_valid <= data_valid_d;
      frame_done <= frame_done_d;
    end
  end
endmodule
`default_nettype wire
